// File: rtl/uart_rx_framed.sv
// UART receiver with configurable data width, parity, 1/2 stop bits, majority-vote sampling,
// break detection and a ready/valid holding register with sticky overrun reporting.
module uart_rx_framed #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY     = 0,
    parameter int SYNC_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_break,
    output logic                 o_overrun
);
    localparam int SPB = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE;
    localparam int CW  = $clog2(SPB);
    localparam int BW  = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SPB - 1);
    localparam logic [CW-1:0] CNT_HALF  = CW'(SPB / 2);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic [2:0]            r_state;
    logic [2:0]            w_next;
    logic [SYNC_DEPTH-1:0] r_sync;
    logic [2:0]            r_hist;
    logic [CW-1:0]         r_cnt;
    logic [BW-1:0]         r_bit;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_perr;
    logic                  r_ferr;
    logic                  r_any1;
    logic                  r_valid;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_perr_out;
    logic                  r_ferr_out;
    logic                  r_brk_out;
    logic                  r_ovr;

    logic w_rx_s;
    logic w_vote;
    logic w_tick;
    logic w_start_smp;
    logic w_data_smp;
    logic w_par_smp;
    logic w_stop_smp;
    logic w_frame_done;
    logic w_ferr_final;
    logic w_brk_final;
    logic w_accept;

    assign w_rx_s = r_sync[SYNC_DEPTH-1];
    assign w_vote = (r_hist[0] & r_hist[1]) | (r_hist[0] & r_hist[2]) | (r_hist[1] & r_hist[2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:      if (!w_rx_s) w_next = S_START;
            S_START:     if (w_start_smp) w_next = w_vote ? S_IDLE : S_DATA;
            S_DATA:      if (w_data_smp && (r_bit == DATA_LAST))
                             w_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY:    if (w_par_smp) w_next = S_STOP;
            S_STOP:      if (w_frame_done) w_next = w_vote ? S_IDLE : S_WAIT_HIGH;
            S_WAIT_HIGH: if (w_rx_s) w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tick      = (r_cnt == CNT_LAST);
        w_start_smp = 1'b0;
        w_data_smp  = 1'b0;
        w_par_smp   = 1'b0;
        w_stop_smp  = 1'b0;
        case (r_state)
            S_START:  w_start_smp = (r_cnt == CNT_HALF);
            S_DATA:   w_data_smp  = w_tick;
            S_PARITY: w_par_smp   = w_tick;
            S_STOP:   w_stop_smp  = w_tick;
            default:  ;
        endcase
        w_frame_done = w_stop_smp && (r_bit == STOP_LAST);
        w_ferr_final = r_ferr | ~w_vote;
        w_brk_final  = w_ferr_final & ~(r_any1 | w_vote);
        w_accept     = r_valid & i_data_ready;
    end

    // Sampling datapath: synchroniser, vote history, bit timing and per-frame accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync  <= '1;
            r_hist  <= '1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_any1  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_DEPTH-2:0], i_rx};
            r_hist <= {r_hist[1:0], w_rx_s};
            case (r_state)
                S_START: r_cnt <= w_start_smp ? '0 : r_cnt + 1'b1;
                S_DATA, S_PARITY, S_STOP: r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                default: r_cnt <= '0;
            endcase
            if (w_start_smp) begin
                r_bit  <= '0;
                r_perr <= 1'b0;
                r_ferr <= 1'b0;
                r_any1 <= 1'b0;
            end
            if (w_data_smp) begin
                r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                r_any1  <= r_any1 | w_vote;
                r_bit   <= (r_bit == DATA_LAST) ? '0 : r_bit + 1'b1;
            end
            if (w_par_smp) begin
                r_perr <= (^r_shift) ^ w_vote ^ PAR_ODD;
                r_any1 <= r_any1 | w_vote;
            end
            if (w_stop_smp) begin
                r_bit  <= r_bit + 1'b1;
                r_ferr <= w_ferr_final;
                r_any1 <= r_any1 | w_vote;
            end
        end
    end

    // A completed frame is dropped only when the held word is neither consumed nor consumable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_perr_out <= 1'b0;
            r_ferr_out <= 1'b0;
            r_brk_out  <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_valid <= 1'b0;
                r_ovr   <= 1'b0;
            end
            if (w_frame_done) begin
                if (!r_valid || i_data_ready) begin
                    r_valid    <= 1'b1;
                    r_data     <= r_shift;
                    r_perr_out <= r_perr;
                    r_ferr_out <= w_ferr_final;
                    r_brk_out  <= w_brk_final;
                end else begin
                    r_ovr <= 1'b1;
                end
            end
        end
    end

    assign o_data_valid = r_valid;
    assign o_data       = r_data;
    assign o_parity_err = r_perr_out;
    assign o_frame_err  = r_ferr_out;
    assign o_break      = r_brk_out;
    assign o_overrun    = r_ovr;
endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed: three configurations (8N1, 7E1, 8N2) at 16 clocks per bit,
// with expected words queued when frames are driven and compared on each accept.
module tb_uart_rx_framed;
    localparam int BIT = 16;

    logic clk = 1'b0;
    logic rst;
    logic rx0, rx1, rx2;
    logic rdy0;
    logic v0, v1, v2;
    logic [7:0] d0;
    logic [6:0] d1;
    logic [7:0] d2;
    logic p0, p1, p2, f0, f1, f2, b0, b1, b2, o0, o1, o2;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;
    int acc0    = 0;

    logic [11:0] exp_q0[$];
    logic [11:0] exp_q1[$];
    logic [11:0] exp_q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_framed #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .i_rx(rx0), .o_data_valid(v0), .i_data_ready(rdy0), .o_data(d0),
        .o_parity_err(p0), .o_frame_err(f0), .o_break(b0), .o_overrun(o0));
    uart_rx_framed #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .STOP_BITS(1), .PARITY(2)) dut1 (
        .clk(clk), .rst(rst), .i_rx(rx1), .o_data_valid(v1), .i_data_ready(1'b1), .o_data(d1),
        .o_parity_err(p1), .o_frame_err(f1), .o_break(b1), .o_overrun(o1));
    uart_rx_framed #(.CLK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .STOP_BITS(2), .PARITY(0)) dut2 (
        .clk(clk), .rst(rst), .i_rx(rx2), .o_data_valid(v2), .i_data_ready(1'b1), .o_data(d2),
        .o_parity_err(p2), .o_frame_err(f2), .o_break(b2), .o_overrun(o2));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] pack(input logic brk, input logic ferr, input logic perr,
                                         input logic [8:0] d);
        return {brk, ferr, perr, d};
    endfunction

    // Scoreboard: every accept pops one expected word; an accept with nothing queued is an error.
    always @(negedge clk) begin
        if (!rst && v0 && rdy0) begin
            acc0 = cyc;
            if (exp_q0.size() == 0) check("dut0_unexpected_word", 1, 0);
            else check("dut0_word", 32'(pack(b0, f0, p0, {1'b0, d0})), 32'(exp_q0.pop_front()));
        end
        if (!rst && v1) begin
            if (exp_q1.size() == 0) check("dut1_unexpected_word", 1, 0);
            else check("dut1_word", 32'(pack(b1, f1, p1, {2'b0, d1})), 32'(exp_q1.pop_front()));
        end
        if (!rst && v2) begin
            if (exp_q2.size() == 0) check("dut2_unexpected_word", 1, 0);
            else check("dut2_word", 32'(pack(b2, f2, p2, {1'b0, d2})), 32'(exp_q2.pop_front()));
        end
    end

    task automatic set_rx(input int idx, input logic v);
        case (idx)
            0:       rx0 = v;
            1:       rx1 = v;
            default: rx2 = v;
        endcase
    endtask

    // Drives one frame; glitch selects a line bit index that gets a one-cycle low at its centre.
    task automatic send(input int idx, input logic [8:0] d, input int nd, input int pmode,
                        input logic pflip, input int nstop, input logic s2, input int glitch);
        logic [15:0] bits;
        logic        p;
        int          n;
        bits    = '1;
        bits[0] = 1'b0;
        p       = 1'b0;
        for (int i = 0; i < nd; i++) begin
            bits[1+i] = d[i];
            p = p ^ d[i];
        end
        n = 1 + nd;
        if (pmode != 0) begin
            bits[n] = ((pmode == 1) ? ~p : p) ^ pflip;
            n++;
        end
        bits[n] = 1'b1;
        n++;
        if (nstop == 2) begin
            bits[n] = s2;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < BIT; c++) begin
                @(negedge clk);
                if (i == 0 && c == 0) t0 = cyc;
                set_rx(idx, (i == glitch && c == 8) ? 1'b0 : bits[i]);
            end
        end
        @(negedge clk);
        set_rx(idx, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_dut0_zero(input string tag);
        check({tag, "_valid"}, 32'(v0), 0);
        check({tag, "_data"}, 32'(d0), 0);
        check({tag, "_flags"}, 32'({p0, f0, b0}), 0);
        check({tag, "_overrun"}, 32'(o0), 0);
    endtask

    initial begin
        logic [8:0] r;
        rst  = 1'b1;
        rx0  = 1'b1;
        rx1  = 1'b1;
        rx2  = 1'b1;
        rdy0 = 1'b1;
        idle(5);
        check_dut0_zero("reset");
        check("reset_dut1_valid", 32'(v1), 0);
        check("reset_dut2_valid", 32'(v2), 0);
        rst = 1'b0;
        idle(10);

        // 8N1 0xA5, with completion-to-valid latency bounded around the stop-bit centre
        exp_q0.push_back(pack(0, 0, 0, 9'h0A5));
        send(0, 9'h0A5, 8, 0, 0, 1, 1, -1);
        idle(4);
        check("a5_latency_window", 32'((acc0 - t0 >= 150) && (acc0 - t0 <= 165)), 1);
        check("a5_single_cycle_valid", 32'(v0), 0);
        idle(20);

        // 7E1: wrong parity then correct parity
        exp_q1.push_back(pack(0, 0, 1, 9'h041));
        send(1, 9'h041, 7, 2, 1, 1, 1, -1);
        idle(20);
        exp_q1.push_back(pack(0, 0, 0, 9'h02A));
        send(1, 9'h02A, 7, 2, 0, 1, 1, -1);
        idle(20);

        // False start: 4-cycle low pulse, then a clean frame
        @(negedge clk);
        rx0 = 1'b0;
        idle(4);
        rx0 = 1'b1;
        idle(40);
        check("false_start_idle_state", 32'(dut0.r_state), 0);
        check("false_start_no_valid", 32'(v0), 0);
        exp_q0.push_back(pack(0, 0, 0, 9'h03C));
        send(0, 9'h03C, 8, 0, 0, 1, 1, -1);
        idle(20);

        // 8N2: second stop low -> frame error, then a long break
        exp_q2.push_back(pack(0, 1, 0, 9'h096));
        send(2, 9'h096, 8, 0, 0, 2, 0, -1);
        idle(30);
        exp_q2.push_back(pack(1, 1, 0, 9'h000));
        @(negedge clk);
        rx2 = 1'b0;
        idle(25 * BIT);
        rx2 = 1'b1;
        idle(30);
        exp_q2.push_back(pack(0, 0, 0, 9'h03C));
        send(2, 9'h03C, 8, 0, 0, 2, 1, -1);
        idle(20);

        // Overrun: ready low, two frames; the first is held, the second dropped
        rdy0 = 1'b0;
        exp_q0.push_back(pack(0, 0, 0, 9'h011));
        send(0, 9'h011, 8, 0, 0, 1, 1, -1);
        idle(20);
        check("ovr_not_yet", 32'(o0), 0);
        send(0, 9'h022, 8, 0, 0, 1, 1, -1);
        idle(20);
        check("ovr_valid_held", 32'(v0), 1);
        check("ovr_data_kept", 32'(d0), 32'h11);
        check("ovr_flag", 32'(o0), 1);
        @(posedge clk);
        #1 rdy0 = 1'b1;
        idle(2);
        check("ovr_valid_cleared", 32'(v0), 0);
        check("ovr_flag_cleared", 32'(o0), 0);
        idle(20);

        // Glitch at bit centre of 0xFF is outvoted
        exp_q0.push_back(pack(0, 0, 0, 9'h0FF));
        send(0, 9'h0FF, 8, 0, 0, 1, 1, 4);
        idle(20);

        // Random bytes
        for (int k = 0; k < 3; k++) begin
            r = 9'($urandom_range(0, 255));
            exp_q0.push_back(pack(0, 0, 0, r));
            send(0, r, 8, 0, 0, 1, 1, -1);
            idle(20);
        end

        // Reset mid-frame with a word held, then a clean frame
        rdy0 = 1'b0;
        send(0, 9'h077, 8, 0, 0, 1, 1, -1);
        idle(20);
        check("pre_reset_held", 32'(v0), 1);
        @(negedge clk);
        rx0 = 1'b0;
        idle(3 * BIT);
        rst = 1'b1;
        #1;
        check_dut0_zero("mid_reset");
        idle(3);
        rx0  = 1'b1;
        rdy0 = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(20);
        exp_q0.push_back(pack(0, 0, 0, 9'h05A));
        send(0, 9'h05A, 8, 0, 0, 1, 1, -1);
        idle(50);

        check("dut0_queue_drained", 32'(exp_q0.size()), 0);
        check("dut1_queue_drained", 32'(exp_q1.size()), 0);
        check("dut2_queue_drained", 32'(exp_q2.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
